// File: rtl/display_pkg.sv
// Shared constants, digit-index type and nibble helpers for the multiplexed display scanner.
package display_pkg;

  localparam int NUM_DIGITS          = 4;
  localparam int DIGIT_W             = 4;
  localparam int DEFAULT_REFRESH_DIV = 50000;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

  // True when idx > 0 and every nibble from idx up to the top digit is zero.
  function automatic logic upper_zero(input logic [NUM_DIGITS*DIGIT_W-1:0] value,
                                      input digit_idx_t idx);
    logic zero;
    zero = (idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && value[i*DIGIT_W +: DIGIT_W] != '0) zero = 1'b0;
    end
    return zero;
  endfunction

endpackage

// File: rtl/module_refresh_tick.sv
// Refresh prescaler: counts 0..DIV-1 while enabled and pulses tick_o on the last count.
module module_refresh_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;

  assign tick_o = en_i && (count_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= tick_o ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/module_display_scan.sv
// Four-digit multiplexed display scanner with registered anode/digit/index outputs.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module module_display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic                          load_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data_i,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [DIGIT_W-1:0]            digit_o,
  output logic [1:0]                    idx_o
);

  logic [NUM_DIGITS*DIGIT_W-1:0] value_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] value_next;
  digit_idx_t                    idx_q;
  digit_idx_t                    idx_next;
  logic [NUM_DIGITS-1:0]         an_next;
  logic                          tick;

  module_refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_i),
    .tick_o (tick)
  );

  // Outputs are built from the post-load value so a load in a tick cycle lands on the new slot.
  always_comb begin
    value_next       = load_i ? data_i : value_q;
    idx_next         = tick ? idx_q + 2'd1 : idx_q;
    an_next          = AN_OFF;
    an_next[idx_next] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (upper_zero(value_next, idx_next)) an_next = AN_OFF;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      an_o    <= AN_OFF;
      digit_o <= '0;
    end else if (en_i) begin
      idx_q   <= idx_next;
      an_o    <= an_next;
      digit_o <= value_next[idx_next*DIGIT_W +: DIGIT_W];
    end else begin
      an_o    <= AN_OFF;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: tb/tb_module_display_scan.sv
// Directed-vector bench for module_display_scan with REFRESH_DIV=4.
module tb_module_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] data_i = 16'h0000;
  logic [3:0]  an_o;
  logic [3:0]  digit_o;
  logic [1:0]  idx_o;

  int total = 0;
  int bad   = 0;

  module_display_scan #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .load_i  (load_i),
    .data_i  (data_i),
    .an_o    (an_o),
    .digit_o (digit_o),
    .idx_o   (idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] data;
    int          n;
    logic [3:0]  an;
    logic [3:0]  dig;
    logic [1:0]  idx;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [3:0] an_x, input logic [3:0] dig_x,
                       input logic [1:0] idx_x);
    total++;
    if (an_o !== an_x || digit_o !== dig_x || idx_o !== idx_x) begin
      bad++;
      $display("FAIL %s t=%0t: got an=%b digit=%h idx=%0d, want an=%b digit=%h idx=%0d",
               name, $time, an_o, digit_o, idx_o, an_x, dig_x, idx_x);
    end
  endtask

  // Each vector drives its inputs for n edges (load only on the first) and checks after every edge.
  task automatic run_vecs(input int first, input int last);
    for (int v = first; v <= last; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        en_i   = vecs[v].en;
        load_i = vecs[v].load && (k == 0);
        data_i = vecs[v].data;
        @(posedge clk);
        #1;
        load_i = 1'b0;
        check($sformatf("vec%0d.%0d", v, k), vecs[v].an, vecs[v].dig, vecs[v].idx);
      end
    end
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1 check(name, 4'b1111, 4'h0, 2'd0);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] an_s2, an_s3;
`ifdef LEADING_ZERO_BLANK_EN
    an_s2 = 4'b1111; an_s3 = 4'b1111;
`else
    an_s2 = 4'b1011; an_s3 = 4'b0111;
`endif
    vecs[0]  = '{1'b1, 1'b0, 16'h0000,  3, 4'b1110, 4'h0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000,  4, 4'b1101, 4'h0, 2'd1};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000,  4, 4'b1011, 4'h0, 2'd2};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000,  4, 4'b0111, 4'h0, 2'd3};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000,  1, 4'b1110, 4'h0, 2'd0};
    vecs[5]  = '{1'b1, 1'b1, 16'h1234,  3, 4'b1110, 4'h4, 2'd0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000,  4, 4'b1101, 4'h3, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000,  4, 4'b1011, 4'h2, 2'd2};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000,  4, 4'b0111, 4'h1, 2'd3};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000,  4, 4'b1110, 4'h4, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 16'h0000,  4, 4'b1101, 4'h3, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 16'hABCD,  1, 4'b1011, 4'hB, 2'd2};
    vecs[12] = '{1'b1, 1'b0, 16'h0000,  1, 4'b1011, 4'hB, 2'd2};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 10, 4'b1111, 4'hB, 2'd2};
    vecs[14] = '{1'b1, 1'b0, 16'h0000,  2, 4'b1011, 4'hB, 2'd2};
    vecs[15] = '{1'b1, 1'b0, 16'h0000,  4, 4'b0111, 4'hA, 2'd3};
    vecs[16] = '{1'b1, 1'b0, 16'h0000,  1, 4'b1110, 4'hD, 2'd0};
    vecs[17] = '{1'b1, 1'b0, 16'h0000,  3, 4'b1110, 4'h0, 2'd0};
    vecs[18] = '{1'b1, 1'b0, 16'h0000,  1, 4'b1101, 4'h0, 2'd1};
    vecs[19] = '{1'b1, 1'b1, 16'h0050,  3, 4'b1110, 4'h0, 2'd0};
    vecs[20] = '{1'b1, 1'b0, 16'h0000,  4, 4'b1101, 4'h5, 2'd1};
    vecs[21] = '{1'b1, 1'b0, 16'h0000,  4, an_s2,   4'h0, 2'd2};
    vecs[22] = '{1'b1, 1'b0, 16'h0000,  4, an_s3,   4'h0, 2'd3};
    vecs[23] = '{1'b1, 1'b0, 16'h0000,  1, 4'b1110, 4'h0, 2'd0};
    vecs[24] = '{1'b1, 1'b0, 16'h0000,  1, 4'b1110, 4'h0, 2'd0};

    repeat (2) @(posedge clk);
    #1 check("reset_hold", 4'b1111, 4'h0, 2'd0);
    #2 rst = 1'b0;

    // Plain scan, 1234 load, ABCD load on a tick, enable gap, wrap.
    run_vecs(0, 16);

    // Reset mid-slot 0 after ABCD was loaded; value must clear (slot 1 shows 0, not C).
    async_reset("async_rst1");
    run_vecs(17, 18);

    async_reset("async_rst2");
    run_vecs(19, 23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule

// File: doc/module_display_scan.md
MODULE_DISPLAY_SCAN -- requirements
Module: module_display_scan

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: en_i  input  1  scan enable; low blanks display and freezes scan state.
REQ-005 Port: load_i  input  1  single-cycle strobe; capture data_i.
REQ-006 Port: data_i  input  16  four packed 4-bit digit codes, digit 0 in [3:0], digit 3 in [15:12].
REQ-007 Port: an_o  output  4  registered digit enables, active-low, at most one bit low.
REQ-008 Port: digit_o  output  4  registered 4-bit code of the active digit, for the downstream 7-segment decoder stage.
REQ-009 Port: idx_o  output  2  registered index of the active digit.

Function
REQ-010 Block SHALL hold a 16-bit value register value_q, written with data_i on any edge where load_i=1, regardless of en_i.
REQ-011 Prescaler SHALL count 0..REFRESH_DIV-1 while en_i=1, wrap to 0, and assert internal tick for exactly the one cycle where count=REFRESH_DIV-1.
REQ-012 Digit index SHALL advance by 1 on each tick, wrapping 3->0.
REQ-013 On every edge with en_i=1: an_o SHALL be 1 everywhere except bit[next idx]=0, digit_o SHALL be value_q_next[4*idx+3:4*idx], idx_o SHALL be next idx.
REQ-014 Latency: load_i sampled at edge k SHALL be visible on digit_o at edge k+1 if the addressed digit is active.
REQ-015 Simultaneous load_i and tick: new index SHALL display the newly loaded nibble at the following edge.
REQ-016 en_i=0: prescaler and index SHALL hold, an_o SHALL be 4'b1111, digit_o SHALL hold its last value.
REQ-017 en_i 0->1: scan SHALL resume from the held index and count, no skipped or repeated slot.
REQ-018 No state machine other than prescaler and index counter; no combinational path from any input to any output.

Reset
REQ-019 While rst=1: value_q=16'h0000, count=0, idx=0, an_o=4'b1111, digit_o=4'h0, idx_o=2'd0.
REQ-020 First edge after rst deassertion with en_i=1 SHALL give an_o=4'b1110, digit_o=value_q[3:0].
REQ-021 rst asserted mid-slot SHALL take effect immediately, without waiting for a clock edge or the end of the slot.

Configuration
REQ-022 Macro LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-023 With LEADING_ZERO_BLANK_EN defined: for the active digit i>0, if value_q nibbles i..3 are all zero, an_o SHALL be 4'b1111 for that slot; digit 0 is never blanked; timing is unchanged.
REQ-024 Without LEADING_ZERO_BLANK_EN: all four digits SHALL be shown unconditionally.

Structure
REQ-025 Package display_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=4, DEFAULT_REFRESH_DIV=50000, AN_OFF=4'b1111, and the digit-index typedef.
REQ-026 Prescaler SHALL be the sub-module module_refresh_tick (parameter DIV, ports clk, rst, en_i, tick_o).
REQ-027 Counter width SHALL be $clog2(REFRESH_DIV).

Verification (bench uses REFRESH_DIV=4)
REQ-028 Reset release, en_i=1, no load -> an_o 1110,1101,1011,0111 in slots of 4 cycles, each showing digit_o=0, then wraps to 1110.
REQ-029 load_i with data_i=16'h1234 -> digit_o=4,3,2,1 in slots 0..3, and an_o one-hot-low matching idx_o.
REQ-030 load_i=1 in the tick cycle of slot 1 with data_i=16'hABCD -> the slot-2 edge shows digit_o=4'hB.
REQ-031 en_i=0 for 10 cycles mid-slot 2 -> an_o=1111, idx_o held at 2; after re-enable, the remaining slot-2 cycles complete before idx_o=3.
REQ-032 LEADING_ZERO_BLANK_EN defined, data_i=16'h0050 -> slots 0,1 active (digit 0, 5), slots 2,3 an_o=1111; undefined -> all four active.
REQ-033 rst pulse of 3 ns between clock edges mid-scan -> an_o=1111 and value_q=0 immediately; restart at idx 0.
